// File: rtl/ucie_mbtrain_pkg.sv
// Shared MBTRAIN definitions: sideband message codes and the self-cal TX state encoding.
package ucie_mbtrain_pkg;

  localparam logic [3:0] SB_NONE             = 4'b0000;
  localparam logic [3:0] SB_SELFCAL_END_REQ  = 4'b0001;
  localparam logic [3:0] SB_SELFCAL_END_RESP = 4'b0010;

  typedef enum logic [2:0] {
    ST_IDLE              = 3'd0,
    ST_LOCAL_CAL         = 3'd1,
    ST_SEND_END_REQ      = 3'd2,
    ST_WAIT_FOR_END_RESP = 3'd3,
    ST_TEST_FINISHED     = 3'd4
  } selfcal_tx_state_e;

  // True when a qualified incoming sideband message carries the given code.
  function automatic logic sb_msg_match(input logic       vld,
                                        input logic [3:0] msg,
                                        input logic [3:0] code);
    return vld && (msg == code);
  endfunction

endpackage

// File: rtl/sb_valid_ctl.sv
// Sideband TX valid handshake: registered valid with a pending request that
// waits while a higher-priority client owns the shared TX mux.
module sb_valid_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic req_i,
  input  logic yield_i,
  input  logic busy_negedge_i,
  output logic valid_o,
  output logic valid_fall_o
);

  logic valid_q, valid_d;
  logic pending_q, pending_d;
  logic valid_dly_q, valid_dly_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pending_q   <= 1'b0;
      valid_dly_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pending_q   <= pending_d;
      valid_dly_q <= valid_dly_d;
    end
  end

  // A request landing on the same edge as the busy negedge is parked in
  // pending rather than dropped, so it is granted on the following edge.
  always_comb begin
    valid_d     = valid_q;
    pending_d   = pending_q;
    valid_dly_d = valid_q;
    if (clr_i) begin
      valid_d     = 1'b0;
      pending_d   = 1'b0;
      valid_dly_d = 1'b0;
    end else if (busy_negedge_i) begin
      valid_d = 1'b0;
      if (req_i) begin
        pending_d = 1'b1;
      end
    end else if ((req_i || pending_q) && !yield_i) begin
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end else if (req_i) begin
      pending_d = 1'b1;
    end
  end

  assign valid_o      = valid_q;
  assign valid_fall_o = valid_dly_q && !valid_q;

endmodule

// File: rtl/selfcal_tx.sv
// MBTRAIN self-calibration TX handler: local calibration window, end request
// over sideband, wait for end response, then sticky test acknowledge.
module selfcal_tx
  import ucie_mbtrain_pkg::*;
#(
  parameter int unsigned CAL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [3:0] i_decoded_sideband_message,
  input  logic       i_sideband_valid,
  input  logic       i_busy_negedge_detected,
  input  logic       i_valid_rx,
  output logic [3:0] o_sideband_message,
  output logic       o_valid_tx,
  output logic       o_cal_en,
  output logic       o_test_ack
);

  localparam int unsigned CNT_W = $clog2(CAL_CYCLES + 1);

  selfcal_tx_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cal_en_q, cal_en_d;
  logic [3:0]        msg_q, msg_d;
  logic              ack_q, ack_d;
  logic              resp_seen_q, resp_seen_d;

  logic cal_done;
  logic resp_hit;
  logic req_cond;
  logic valid_clr;
  logic valid_tx;
  logic valid_fall;

  assign cal_done  = (cnt_q == CNT_W'(CAL_CYCLES - 1));
  assign resp_hit  = sb_msg_match(i_sideband_valid, i_decoded_sideband_message,
                                  SB_SELFCAL_END_RESP);
  assign req_cond  = i_en && (state_q == ST_LOCAL_CAL) && cal_done;
  assign valid_clr = !i_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cal_en_q    <= 1'b0;
      msg_q       <= SB_NONE;
      ack_q       <= 1'b0;
      resp_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cal_en_q    <= cal_en_d;
      msg_q       <= msg_d;
      ack_q       <= ack_d;
      resp_seen_q <= resp_seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:              state_d = ST_LOCAL_CAL;
        ST_LOCAL_CAL:         if (cal_done) state_d = ST_SEND_END_REQ;
        ST_SEND_END_REQ:      if (valid_fall) state_d = ST_WAIT_FOR_END_RESP;
        ST_WAIT_FOR_END_RESP: if (resp_seen_q || resp_hit) state_d = ST_TEST_FINISHED;
        ST_TEST_FINISHED:     state_d = ST_TEST_FINISHED;
        default:              state_d = ST_IDLE;
      endcase
    end
  end

  // The end response may arrive before our own valid has fallen, so it is
  // latched from SEND_END_REQ onwards and consumed on entry to WAIT.
  always_comb begin
    cnt_d       = cnt_q;
    cal_en_d    = cal_en_q;
    msg_d       = msg_q;
    ack_d       = ack_q;
    resp_seen_d = resp_seen_q;
    if (!i_en) begin
      cnt_d       = '0;
      cal_en_d    = 1'b0;
      msg_d       = SB_NONE;
      ack_d       = 1'b0;
      resp_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d       = '0;
          cal_en_d    = 1'b1;
          msg_d       = SB_NONE;
          ack_d       = 1'b0;
          resp_seen_d = 1'b0;
        end
        ST_LOCAL_CAL: begin
          cnt_d = cnt_q + 1'b1;
          if (cal_done) begin
            cal_en_d = 1'b0;
            msg_d    = SB_SELFCAL_END_REQ;
          end
        end
        ST_SEND_END_REQ: begin
          if (resp_hit) begin
            resp_seen_d = 1'b1;
          end
        end
        ST_WAIT_FOR_END_RESP: begin
          if (resp_hit) begin
            resp_seen_d = 1'b1;
          end
          if (resp_seen_q || resp_hit) begin
            ack_d = 1'b1;
            msg_d = SB_NONE;
          end
        end
        ST_TEST_FINISHED: begin
          ack_d = 1'b1;
        end
        default: begin
          cnt_d    = '0;
          cal_en_d = 1'b0;
          msg_d    = SB_NONE;
          ack_d    = 1'b0;
        end
      endcase
    end
  end

  sb_valid_ctl u_valid_ctl (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_i          (valid_clr),
    .req_i          (req_cond),
    .yield_i        (i_valid_rx),
    .busy_negedge_i (i_busy_negedge_detected),
    .valid_o        (valid_tx),
    .valid_fall_o   (valid_fall)
  );

  assign o_sideband_message = msg_q;
  assign o_valid_tx         = valid_tx;
  assign o_cal_en           = cal_en_q;
  assign o_test_ack         = ack_q;

endmodule
